// File: rtl/psram_async_ctrl.sv
// OPB slave bridging 16/32-bit accesses onto an address/data-multiplexed async PSRAM bus.
// Define PSRAM_READ32_EN to split 32-bit reads into two 16-bit phases; otherwise reads are 16-bit.
module psram_async_ctrl #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned WR_WAIT = 4,
    parameter int unsigned RD_WAIT = 4,
    parameter int unsigned RECOVER = 2
) (
    input  logic              OPB_Clk,
    input  logic              OPB_Rst,
    input  logic [ADDR_W-1:0] OPB_ABus,
    input  logic [3:0]        OPB_BE,
    input  logic [31:0]       OPB_DBus,
    input  logic              OPB_32Bit,
    input  logic              OPB_RNW,
    input  logic              OPB_select,
    output logic [31:0]       Sln_DBus,
    output logic              Sln_xferAck,
    input  logic [15:0]       PSRAM_Mem_DQ_I,
    output logic [15:0]       PSRAM_Mem_DQ_O,
    output logic              PSRAM_Mem_DQ_OE,
    output logic [ADDR_W-3:0] PSRAM_Mem_A,
    output logic [1:0]        PSRAM_Mem_BE,
    output logic              PSRAM_Mem_WE,
    output logic              PSRAM_Mem_OEN,
    output logic              PSRAM_Mem_CEN0,
    output logic              PSRAM_Mem_CEN1,
    output logic              PSRAM_Mem_ADV
);

`ifdef PSRAM_READ32_EN
    localparam bit READ32 = 1'b1;
`else
    localparam bit READ32 = 1'b0;
`endif

    localparam logic [7:0] WR_LOAD  = 8'(WR_WAIT - 1);
    localparam logic [7:0] RD_LOAD  = 8'(RD_WAIT - 1);
    localparam logic [7:0] REC_LOAD = (RECOVER == 0) ? 8'd0 : 8'(RECOVER - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWrData,
        StRdWait,
        StRdCap,
        StRecov,
        StAck
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic                sel_q;
    logic [ADDR_W-1:0]   abus_q;
    logic [3:0]          be_q;
    logic [31:0]         dbus_q;
    logic                rnw_q;
    logic                b32_q;
    logic [15:0]         cap_hi_q;
    logic [15:0]         cap_lo_q;
    logic [31:0]         rdata_q;

    logic                start;
    logic                in_two_phase;
    logic                two_phase;
    logic [ADDR_W-3:0]   word_addr;
    logic [15:0]         ph_data;
    logic [1:0]          ph_be;
    logic                cen_on;
    logic [15:0]         next_lo;
    logic [31:0]         rdata_d;
    logic                rdata_load;
    logic                unused_abus0;

    assign unused_abus0 = abus_q[0];

    assign start        = OPB_select & ~sel_q;
    assign in_two_phase = OPB_32Bit & (~OPB_RNW | READ32);
    assign two_phase    = b32_q & (~rnw_q | READ32);

    // Phase 1 is always the final phase; single-phase accesses start directly in phase 1.
    assign word_addr = two_phase ? {abus_q[ADDR_W-2:2], phase_q} : abus_q[ADDR_W-2:1];
    assign ph_data   = phase_q ? dbus_q[15:0] : dbus_q[31:16];
    assign ph_be     = phase_q ? ~be_q[1:0] : ~be_q[3:2];

    // Forward the word being captured so RECOVER == 0 still returns fresh data.
    assign next_lo    = (state_q == StRdCap && phase_q) ? PSRAM_Mem_DQ_I : cap_lo_q;
    assign rdata_d    = two_phase ? {cap_hi_q, next_lo} : {next_lo, next_lo};
    assign rdata_load = (state_d == StAck) && (state_q != StAck) && rnw_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAddr;
                    phase_d = ~in_two_phase;
                end
            end
            StAddr: begin
                if (rnw_q) begin
                    state_d = StRdWait;
                    cnt_d   = RD_LOAD;
                end else begin
                    state_d = StWrData;
                    cnt_d   = WR_LOAD;
                end
            end
            StWrData, StRdCap: begin
                if (state_q == StRdCap || cnt_q == 8'd0) begin
                    cnt_d = REC_LOAD;
                    if (RECOVER != 0) begin
                        state_d = StRecov;
                    end else if (phase_q) begin
                        state_d = StAck;
                    end else begin
                        state_d = StAddr;
                        phase_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StRdWait: begin
                if (cnt_q == 8'd0) begin
                    state_d = StRdCap;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StRecov: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (phase_q) begin
                    state_d = StAck;
                end else begin
                    state_d = StAddr;
                    phase_d = 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        PSRAM_Mem_ADV   = 1'b1;
        PSRAM_Mem_WE    = 1'b1;
        PSRAM_Mem_OEN   = 1'b1;
        PSRAM_Mem_BE    = 2'b11;
        PSRAM_Mem_DQ_OE = 1'b0;
        PSRAM_Mem_DQ_O  = 16'h0000;
        cen_on          = 1'b0;

        unique case (state_q)
            StAddr: begin
                cen_on          = 1'b1;
                PSRAM_Mem_ADV   = 1'b0;
                PSRAM_Mem_DQ_OE = 1'b1;
                PSRAM_Mem_DQ_O  = word_addr[15:0];
                PSRAM_Mem_BE    = rnw_q ? 2'b00 : ph_be;
            end
            StWrData: begin
                cen_on          = 1'b1;
                PSRAM_Mem_WE    = 1'b0;
                PSRAM_Mem_DQ_OE = 1'b1;
                PSRAM_Mem_DQ_O  = ph_data;
                PSRAM_Mem_BE    = ph_be;
            end
            StRdWait, StRdCap: begin
                cen_on        = 1'b1;
                PSRAM_Mem_OEN = 1'b0;
                PSRAM_Mem_BE  = 2'b00;
            end
            default: begin
            end
        endcase

        PSRAM_Mem_CEN0 = ~(cen_on & ~abus_q[ADDR_W-1]);
        PSRAM_Mem_CEN1 = ~(cen_on & abus_q[ADDR_W-1]);
    end

    assign PSRAM_Mem_A = word_addr;
    assign Sln_xferAck = (state_q == StAck);
    assign Sln_DBus    = rdata_q;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            phase_q  <= 1'b0;
            sel_q    <= 1'b0;
            abus_q   <= '0;
            be_q     <= 4'h0;
            dbus_q   <= 32'h0;
            rnw_q    <= 1'b0;
            b32_q    <= 1'b0;
            cap_hi_q <= 16'h0;
            cap_lo_q <= 16'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            sel_q   <= OPB_select;
            if (state_q == StIdle && start) begin
                abus_q <= OPB_ABus;
                be_q   <= OPB_BE;
                dbus_q <= OPB_DBus;
                rnw_q  <= OPB_RNW;
                b32_q  <= OPB_32Bit;
            end
            if (state_q == StRdCap) begin
                if (phase_q) begin
                    cap_lo_q <= PSRAM_Mem_DQ_I;
                end else begin
                    cap_hi_q <= PSRAM_Mem_DQ_I;
                end
            end
            if (rdata_load) begin
                rdata_q <= rdata_d;
            end
        end
    end

endmodule

// File: tb/tb_psram_async_ctrl.sv
// Scoreboard bench for psram_async_ctrl: directed OPB transfers against a small PSRAM read model.
module tb_psram_async_ctrl;

    typedef struct {
        logic [31:0] data;
        int unsigned lat;
        int unsigned start;
    } ack_exp_t;

    typedef struct {
        logic [1:0]  cen;
        logic [21:0] a;
        logic [15:0] d;
        logic [1:0]  be;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] abus = '0;
    logic [3:0]  be = '0;
    logic [31:0] dbus = '0;
    logic        b32 = 1'b0;
    logic        rnw = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] sln_dbus;
    logic        ack;
    logic [15:0] dq_i;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic [21:0] mem_a;
    logic [1:0]  mem_be;
    logic        mem_we, mem_oen, cen0, cen1, adv;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    int unsigned ack_cnt = 0;
    int unsigned exp_acks = 0;
    logic [31:0] last_rd = 32'h0;

    ack_exp_t sbq[$];
    wr_exp_t  wq[$];

    psram_async_ctrl dut (
        .OPB_Clk         (clk),
        .OPB_Rst         (rst_n),
        .OPB_ABus        (abus),
        .OPB_BE          (be),
        .OPB_DBus        (dbus),
        .OPB_32Bit       (b32),
        .OPB_RNW         (rnw),
        .OPB_select      (sel),
        .Sln_DBus        (sln_dbus),
        .Sln_xferAck     (ack),
        .PSRAM_Mem_DQ_I  (dq_i),
        .PSRAM_Mem_DQ_O  (dq_o),
        .PSRAM_Mem_DQ_OE (dq_oe),
        .PSRAM_Mem_A     (mem_a),
        .PSRAM_Mem_BE    (mem_be),
        .PSRAM_Mem_WE    (mem_we),
        .PSRAM_Mem_OEN   (mem_oen),
        .PSRAM_Mem_CEN0  (cen0),
        .PSRAM_Mem_CEN1  (cen1),
        .PSRAM_Mem_ADV   (adv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PSRAM read model: address latched while ADV is low.
    logic [21:0] mdl_addr = '0;
    always @(posedge clk) if (!adv) mdl_addr <= mem_a;
    always_comb begin
        dq_i = 16'hDEAD;
        case (mdl_addr)
            22'd2:   dq_i = 16'h1357;
            22'd8:   dq_i = 16'hAAAA;
            22'd9:   dq_i = 16'h5555;
            default: dq_i = 16'hDEAD;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Ack monitor: every completion pops one expected response.
    always @(negedge clk) begin : mon_ack
        ack_exp_t e;
        if (rst_n && ack) begin
            ack_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                e = sbq.pop_front();
                check("sln_dbus", sln_dbus, e.data);
                check("latency", cyc - e.start, e.lat);
            end
        end
    end

    // Write-phase monitor: samples the first WE-low cycle, compares when WE returns high.
    int unsigned we_run = 0;
    logic [1:0]  cap_cen;
    logic [21:0] cap_a;
    logic [15:0] cap_d;
    logic [1:0]  cap_be;
    logic        cap_oe;
    always @(negedge clk) begin : mon_wr
        wr_exp_t e;
        if (!rst_n) begin
            we_run = 0;
        end else if (!mem_we) begin
            if (we_run == 0) begin
                cap_cen = {cen1, cen0};
                cap_a   = mem_a;
                cap_d   = dq_o;
                cap_be  = mem_be;
                cap_oe  = dq_oe;
            end
            we_run++;
        end else if (we_run != 0) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got write at A=0x%06h expected none", cap_a);
            end else begin
                e = wq.pop_front();
                check("wr_cen", 32'(cap_cen), 32'(e.cen));
                check("wr_addr", 32'(cap_a), 32'(e.a));
                check("wr_data", 32'(cap_d), 32'(e.d));
                check("wr_be", 32'(cap_be), 32'(e.be));
                check("wr_oe", 32'(cap_oe), 32'd1);
                check("we_cycles", we_run, 32'd4);
            end
            we_run = 0;
        end
    end

    task automatic push_wr(input logic [1:0] c, input logic [21:0] a, input logic [15:0] d,
                           input logic [1:0] b);
        wr_exp_t e;
        e.cen = c;
        e.a   = a;
        e.d   = d;
        e.be  = b;
        wq.push_back(e);
    endtask

    // mode 0: normal; 1: select held across completion; 2: select toggled mid-transfer.
    task automatic xfer(input logic [23:0] a, input logic [3:0] b, input logic [31:0] d,
                        input logic is32, input logic rd, input logic [31:0] exp_d,
                        input int unsigned exp_lat, input int mode);
        ack_exp_t e;
        bit done;
        done = 1'b0;
        @(negedge clk);
        abus = a;
        be   = b;
        dbus = d;
        b32  = is32;
        rnw  = rd;
        sel  = 1'b1;
        e.data  = exp_d;
        e.lat   = exp_lat;
        e.start = cyc;
        sbq.push_back(e);
        exp_acks++;
        @(negedge clk);
        abus = ~a;
        be   = ~b;
        dbus = ~d;
        b32  = ~is32;
        rnw  = ~rd;
        if (mode == 2) begin
            repeat (2) @(negedge clk);
            sel = 1'b0;
            @(negedge clk);
            sel = 1'b1;
        end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (ack) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: got no ack in 200 cycles expected one");
            sbq.delete();
        end
        if (mode != 0) begin
            repeat (20) @(negedge clk);
            check("no_retrigger", ack_cnt, exp_acks);
        end
        sel = 1'b0;
        repeat (2) @(negedge clk);
        check("ack_count", ack_cnt, exp_acks);
    endtask

    initial begin
        bit done;
        #3;
        check("rst_strobes", 32'({adv, mem_we, mem_oen, cen0, cen1}), 32'h1f);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dbus", sln_dbus, 32'h0);
        check("rst_addr", 32'(mem_a), 32'h0);
        check("rst_be_oe", 32'({mem_be, dq_oe}), 32'b110);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        push_wr(2'b10, 22'd2, 16'hBEEF, 2'b00);
        xfer(24'h000004, 4'b0011, 32'h0000_BEEF, 1'b0, 1'b0, last_rd, 8, 0);

        push_wr(2'b01, 22'd8, 16'h1234, 2'b00);
        push_wr(2'b01, 22'd9, 16'h5678, 2'b00);
        xfer(24'h800010, 4'b1111, 32'h1234_5678, 1'b1, 1'b0, last_rd, 15, 0);

        push_wr(2'b10, 22'd3, 16'hCAFE, 2'b11);
        xfer(24'h000006, 4'b0000, 32'h0000_CAFE, 1'b0, 1'b0, last_rd, 8, 0);

        push_wr(2'b10, 22'd0, 16'hA5A5, 2'b10);
        push_wr(2'b10, 22'd1, 16'h5A5A, 2'b01);
        xfer(24'h000000, 4'b0110, 32'hA5A5_5A5A, 1'b1, 1'b0, last_rd, 15, 0);

        last_rd = 32'h1357_1357;
        xfer(24'h000004, 4'b1111, 32'h0, 1'b0, 1'b1, last_rd, 9, 0);

`ifdef PSRAM_READ32_EN
        last_rd = 32'hAAAA_5555;
        xfer(24'h000012, 4'b1111, 32'h0, 1'b1, 1'b1, last_rd, 17, 1);
`else
        last_rd = 32'h5555_5555;
        xfer(24'h000012, 4'b1111, 32'h0, 1'b1, 1'b1, last_rd, 9, 1);
`endif

        push_wr(2'b10, 22'd2, 16'h1111, 2'b00);
        xfer(24'h000004, 4'b0011, 32'h0000_1111, 1'b0, 1'b0, last_rd, 8, 2);

        // Abort a write while WE is low.
        @(negedge clk);
        abus = 24'h000004;
        be   = 4'b0011;
        dbus = 32'h0000_7777;
        b32  = 1'b0;
        rnw  = 1'b0;
        sel  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!mem_we) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL abort_we: got WE high for 20 cycles expected WE low");
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_strobes", 32'({adv, mem_we, mem_oen, cen0, cen1}), 32'h1f);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_dbus", sln_dbus, 32'h0);
        check("abort_addr_dq", 32'({mem_a, dq_o}), 32'h0);
        sbq.delete();
        wq.delete();
        sel = 1'b0;
        last_rd = 32'h0;
        repeat (3) @(negedge clk);
        check("abort_no_ack", ack_cnt, exp_acks);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        last_rd = 32'h5555_5555;
        xfer(24'h000012, 4'b1111, 32'h0, 1'b0, 1'b1, last_rd, 9, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 time units expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
